// File: rtl/pwr_monitor_n.sv
// Switching-activity monitor: counts 0->1 transitions on N nets, weights them into
// a per-window energy figure and hands each window total off on a valid/ready port.
module pwr_monitor_n #(
    parameter int N   = 8,
    parameter int CW  = 16,
    parameter int WW  = 4,
    parameter int AW  = 24,
    parameter int WIN = 256,
    parameter int AAW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic            enable,
    input  logic            clear,
    input  logic [N-1:0]    chan_in,
    input  logic [N*WW-1:0] weights,
    input  logic [AAW-1:0]  rd_addr,
    output logic [CW-1:0]   rd_data,
    output logic [AW-1:0]   win_energy,
    output logic            win_valid,
    input  logic            win_ready,
    output logic            cnt_ovf,
    output logic            acc_ovf,
    output logic            win_lost
);

    localparam int EW  = WW + AAW;
    localparam int SW  = ((AW > EW) ? AW : EW) + 1;
    localparam int WCW = $clog2(WIN);
    localparam logic [CW-1:0]  CNT_MAX  = '1;
    localparam logic [AW-1:0]  ACC_MAX  = '1;
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WIN - 1);

    logic [N-1:0]   prev;
    logic [N-1:0]   rise;
    logic [CW-1:0]  cnt [N];
    logic [AW-1:0]  acc;
    logic [WCW-1:0] win_cnt;
    logic [EW-1:0]  e_cyc;
    logic [SW-1:0]  acc_sum;
    logic [AW-1:0]  acc_sat;
    logic           acc_clip;
    logic           win_end;
    logic           xfer;
    logic [CW-1:0]  rd_next;

    // Handshake: win_valid means win_energy holds an unconsumed window total; a
    // transfer happens on any edge with win_valid & win_ready. A window ending on
    // that same edge keeps win_valid high with the new total instead.
    always_comb begin
        rise  = chan_in & ~prev & {N{enable}};
        e_cyc = '0;
        for (int i = 0; i < N; i++) begin
            if (rise[i]) e_cyc = e_cyc + EW'(weights[i*WW +: WW]);
        end
        acc_sum  = SW'(acc) + SW'(e_cyc);
        acc_clip = acc_sum > SW'(ACC_MAX);
        acc_sat  = acc_clip ? ACC_MAX : acc_sum[AW-1:0];
        win_end  = enable && (win_cnt == WIN_LAST);
        xfer     = win_valid && win_ready;
        rd_next  = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_addr == AAW'(i)) rd_next = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            prev       <= '0;
            rd_data    <= '0;
            acc        <= '0;
            win_cnt    <= '0;
            win_energy <= '0;
            win_valid  <= 1'b0;
            cnt_ovf    <= 1'b0;
            acc_ovf    <= 1'b0;
            win_lost   <= 1'b0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            prev    <= chan_in;
            rd_data <= rd_next;
            if (clear) begin
                // Rises seen this cycle are dropped along with the statistics.
                acc        <= '0;
                win_cnt    <= '0;
                win_energy <= '0;
                win_valid  <= 1'b0;
                cnt_ovf    <= 1'b0;
                acc_ovf    <= 1'b0;
                win_lost   <= 1'b0;
                for (int i = 0; i < N; i++) cnt[i] <= '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (rise[i]) begin
                        if (cnt[i] == CNT_MAX) cnt_ovf <= 1'b1;
                        else                   cnt[i]  <= cnt[i] + 1'b1;
                    end
                end
                if (enable && acc_clip) acc_ovf <= 1'b1;
                if (win_end) begin
                    win_energy <= acc_sat;
                    acc        <= '0;
                    win_cnt    <= '0;
                    win_valid  <= 1'b1;
                    if (win_valid && !win_ready) win_lost <= 1'b1;
                end else begin
                    if (xfer) win_valid <= 1'b0;
                    if (enable) begin
                        acc     <= acc_sat;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwr_monitor_n.sv
// Bench for pwr_monitor_n (N=4, CW=4, AW=6, WIN=8): directed scenarios with fixed
// expectations plus a randomized run against a cycle-level arithmetic model.
module tb_pwr_monitor_n;

    localparam int N = 4, CW = 4, WW = 4, AW = 6, WIN = 8, AAW = 3;
    localparam int CNT_MAX = 15, ACC_MAX = 63;

    logic            clk = 1'b0;
    logic            reset_L = 1'b0;
    logic            enable = 1'b0;
    logic            clear = 1'b0;
    logic [N-1:0]    chan_in = '0;
    logic [N*WW-1:0] weights = 16'h4321;
    logic [AAW-1:0]  rd_addr = '0;
    logic [CW-1:0]   rd_data;
    logic [AW-1:0]   win_energy;
    logic            win_valid;
    logic            win_ready = 1'b0;
    logic            cnt_ovf, acc_ovf, win_lost;

    int n_tests = 0;
    int n_fail  = 0;

    pwr_monitor_n #(.N(N), .CW(CW), .WW(WW), .AW(AW), .WIN(WIN), .AAW(AAW)) dut (
        .clk(clk), .reset_L(reset_L), .enable(enable), .clear(clear),
        .chan_in(chan_in), .weights(weights), .rd_addr(rd_addr), .rd_data(rd_data),
        .win_energy(win_energy), .win_valid(win_valid), .win_ready(win_ready),
        .cnt_ovf(cnt_ovf), .acc_ovf(acc_ovf), .win_lost(win_lost)
    );

    always #5 clk = ~clk;

    // Reference model: integer counters and an accumulator updated on each edge.
    int m_cnt [N] = '{default: 0};
    logic [N-1:0] m_prev = '0;
    int m_acc = 0, m_wc = 0, m_we = 0, m_rd = 0;
    bit m_wv = 0, m_cov = 0, m_aov = 0, m_lost = 0;

    always @(posedge clk) begin : model
        logic [N-1:0] r;
        int e, s;
        bit wv_old;
        if (!reset_L) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_prev = '0; m_acc = 0; m_wc = 0; m_we = 0; m_rd = 0;
            m_wv = 0; m_cov = 0; m_aov = 0; m_lost = 0;
        end else begin
            wv_old = m_wv;
            r = chan_in & ~m_prev & {N{enable}};
            m_rd = 0;
            for (int i = 0; i < N; i++) if (int'(rd_addr) == i) m_rd = m_cnt[i];
            m_prev = chan_in;
            if (clear) begin
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
                m_acc = 0; m_wc = 0; m_we = 0; m_wv = 0; m_cov = 0; m_aov = 0; m_lost = 0;
            end else begin
                e = 0;
                for (int i = 0; i < N; i++) begin
                    if (r[i]) begin
                        e += int'(weights[i*WW +: WW]);
                        if (m_cnt[i] == CNT_MAX) m_cov = 1; else m_cnt[i]++;
                    end
                end
                if (m_wv && win_ready) m_wv = 0;
                if (enable) begin
                    s = m_acc + e;
                    if (s > ACC_MAX) begin s = ACC_MAX; m_aov = 1; end
                    if (m_wc == WIN - 1) begin
                        if (wv_old && !win_ready) m_lost = 1;
                        m_we = s; m_acc = 0; m_wc = 0; m_wv = 1;
                    end else begin
                        m_acc = s; m_wc++;
                    end
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] ch, input logic en, input logic rdy,
                        input logic clr, input logic [AAW-1:0] addr);
        chan_in = ch; enable = en; win_ready = rdy; clear = clr; rd_addr = addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        step('0, 1'b0, 1'b0, 1'b0, '0);
        step('0, 1'b0, 1'b0, 1'b0, '0);
        n_tests++;
        if ({rd_data, win_energy, win_valid, cnt_ovf, acc_ovf, win_lost} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rd=%0d we=%0d wv=%b co=%b ao=%b wl=%b required all 0",
                     rd_data, win_energy, win_valid, cnt_ovf, acc_ovf, win_lost);
        end
        reset_L = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(4'(k), 1'b0, 1'b0, 1'b0, 3'(k));
            n_tests++;
            if (win_valid !== 1'b0 || rd_data !== '0) begin
                n_fail++;
                $display("FAIL idle_no_window cyc=%0d got wv=%b rd=%0d required 0/0", k, win_valid, rd_data);
            end
        end
    endtask

    task automatic test_toggle();
        step('0, 1'b0, 1'b1, 1'b1, '0);
        for (int k = 0; k < 8; k++) begin
            step((k % 2 == 0) ? 4'b0101 : 4'b0000, 1'b1, 1'b1, 1'b0, '0);
            if (k < 7) begin
                n_tests++;
                if (win_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL toggle_early_valid cyc=%0d got %b required 0", k, win_valid);
                end
            end
        end
        n_tests++;
        if (win_valid !== 1'b1 || win_energy !== 6'd16) begin
            n_fail++;
            $display("FAIL toggle_window got wv=%b we=%0d required 1/16", win_valid, win_energy);
        end
        step('0, 1'b0, 1'b1, 1'b0, 3'd2);
        n_tests++;
        if (win_valid !== 1'b0 || rd_data !== 4'd4) begin
            n_fail++;
            $display("FAIL toggle_xfer_rd2 got wv=%b rd=%0d required 0/4", win_valid, rd_data);
        end
        step('0, 1'b0, 1'b1, 1'b0, 3'd0);
        n_tests++;
        if (rd_data !== 4'd4) begin
            n_fail++;
            $display("FAIL toggle_rd0 got %0d required 4", rd_data);
        end
    endtask

    task automatic test_lost();
        step('0, 1'b0, 1'b0, 1'b1, '0);
        for (int k = 0; k < 2 * WIN; k++) step(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, '0);
        n_tests++;
        if (win_valid !== 1'b1 || win_lost !== 1'b1 || win_energy !== 6'(m_we)) begin
            n_fail++;
            $display("FAIL lost_two_windows got wv=%b wl=%b we=%0d required 1/1/%0d",
                     win_valid, win_lost, win_energy, m_we);
        end
        step('0, 1'b0, 1'b1, 1'b0, '0);
        n_tests++;
        if (win_valid !== 1'b0 || win_lost !== 1'b1) begin
            n_fail++;
            $display("FAIL lost_drain got wv=%b wl=%b required 0/1", win_valid, win_lost);
        end
    endtask

    task automatic test_saturation();
        step('0, 1'b0, 1'b1, 1'b1, '0);
        for (int k = 0; k < 40; k++) step((k % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1, 1'b1, 1'b0, '0);
        step('0, 1'b0, 1'b1, 1'b0, 3'd1);
        n_tests++;
        if (rd_data !== 4'd15 || cnt_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_sat got rd=%0d co=%b required 15/1", rd_data, cnt_ovf);
        end
        weights = 16'hFFFF;
        step('0, 1'b0, 1'b1, 1'b1, '0);
        for (int k = 0; k < WIN; k++) step((k % 2 == 0) ? 4'b1111 : 4'b0000, 1'b1, 1'b0, 1'b0, '0);
        n_tests++;
        if (win_energy !== 6'd63 || acc_ovf !== 1'b1 || win_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL acc_sat got we=%0d ao=%b wv=%b required 63/1/1", win_energy, acc_ovf, win_valid);
        end
        weights = 16'h4321;
        step('0, 1'b0, 1'b1, 1'b1, '0);
    endtask

    task automatic test_clear();
        step(4'b0001, 1'b1, 1'b0, 1'b0, '0);
        step(4'b0000, 1'b1, 1'b0, 1'b0, '0);
        step(4'b0001, 1'b1, 1'b0, 1'b0, '0);
        step(4'b1000, 1'b1, 1'b0, 1'b1, 3'd3);
        n_tests++;
        if ({win_energy, win_valid, cnt_ovf, acc_ovf, win_lost} !== '0) begin
            n_fail++;
            $display("FAIL clear_flags got we=%0d wv=%b co=%b ao=%b wl=%b required all 0",
                     win_energy, win_valid, cnt_ovf, acc_ovf, win_lost);
        end
        step(4'b1000, 1'b1, 1'b0, 1'b0, 3'd3);
        n_tests++;
        if (rd_data !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_ch3_uncounted got %0d required 0", rd_data);
        end
        for (int k = 0; k < 6; k++) step((k % 2 == 0) ? 4'b1001 : 4'b1000, 1'b1, 1'b0, 1'b0, '0);
        n_tests++;
        if (win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_window_early got wv=%b required 0", win_valid);
        end
        step(4'b1000, 1'b1, 1'b0, 1'b0, '0);
        n_tests++;
        if (win_valid !== 1'b1 || win_energy !== 6'd3) begin
            n_fail++;
            $display("FAIL clear_window_full got wv=%b we=%0d required 1/3", win_valid, win_energy);
        end
    endtask

    task automatic test_enable_gap();
        step('0, 1'b0, 1'b1, 1'b1, '0);
        for (int k = 0; k < 13; k++) begin
            step((k % 2 == 0) ? 4'b0001 : 4'b0000, (k < 3 || k >= 8), 1'b1, 1'b0, '0);
            if (k == 11) begin
                n_tests++;
                if (win_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_window_early got wv=%b required 0", win_valid);
                end
            end
        end
        n_tests++;
        if (win_valid !== 1'b1 || win_energy !== 6'd5) begin
            n_fail++;
            $display("FAIL gap_window got wv=%b we=%0d required 1/5", win_valid, win_energy);
        end
        step('0, 1'b0, 1'b1, 1'b0, 3'd0);
        n_tests++;
        if (rd_data !== 4'd5) begin
            n_fail++;
            $display("FAIL gap_cnt0 got %0d required 5", rd_data);
        end
        step('0, 1'b0, 1'b1, 1'b0, 3'd7);
        n_tests++;
        if (rd_data !== 4'd0) begin
            n_fail++;
            $display("FAIL rd_out_of_range got %0d required 0", rd_data);
        end
    endtask

    task automatic test_random();
        weights = 16'($urandom);
        step('0, 1'b0, 1'b1, 1'b1, '0);
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)));
            n_tests++;
            if (rd_data !== 4'(m_rd) || win_energy !== 6'(m_we) || win_valid !== m_wv ||
                cnt_ovf !== m_cov || acc_ovf !== m_aov || win_lost !== m_lost) begin
                n_fail++;
                $display("FAIL random cyc=%0d got rd=%0d we=%0d wv=%b co=%b ao=%b wl=%b required rd=%0d we=%0d wv=%b co=%b ao=%b wl=%b",
                         k, rd_data, win_energy, win_valid, cnt_ovf, acc_ovf, win_lost,
                         m_rd, m_we, m_wv, m_cov, m_aov, m_lost);
            end
        end
        reset_L = 1'b0;
        step(4'b1111, 1'b1, 1'b0, 1'b0, 3'd1);
        reset_L = 1'b1;
        step('0, 1'b0, 1'b0, 1'b0, 3'd1);
        n_tests++;
        if ({rd_data, win_energy, win_valid, cnt_ovf, acc_ovf, win_lost} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run got rd=%0d we=%0d wv=%b required all 0", rd_data, win_energy, win_valid);
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_lost();
        test_saturation();
        test_clear();
        test_enable_gap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
